// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port among writeback requesters,
// with a registered write stage and a per-register pending-write scoreboard.
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int NUM_REQ    = 2,
    localparam int AW        = $clog2(NUM_REGS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*AW-1:0]         req_rd,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [AW-1:0]                 rf_rd,
    output logic [DATA_WIDTH-1:0]         rf_d,
    output logic                          rf_we,
    input  logic                          iss_valid,
    input  logic [AW-1:0]                 iss_rd,
    input  logic [AW-1:0]                 chk_ra,
    input  logic [AW-1:0]                 chk_rb,
    output logic                          hazard_a,
    output logic                          hazard_b,
    output logic [NUM_REGS-1:0]           busy
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0]         rr_ptr;
    logic [PW-1:0]         nxt_ptr;
    logic                  xfer;
    logic [NUM_REQ-1:0]    grant;
    logic [AW-1:0]         sel_rd;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [NUM_REGS-1:0]   busy_q;
    int unsigned           idx;

    // Search starts at rr_ptr and wraps; the first valid requester wins.
    always_comb begin
        grant    = '0;
        xfer     = 1'b0;
        nxt_ptr  = rr_ptr;
        sel_rd   = '0;
        sel_data = '0;
        idx      = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(rr_ptr) + k) % NUM_REQ;
            if (!xfer && req_valid[idx]) begin
                xfer       = 1'b1;
                grant[idx] = 1'b1;
                sel_rd     = req_rd[idx*AW +: AW];
                sel_data   = req_data[idx*DATA_WIDTH +: DATA_WIDTH];
                nxt_ptr    = (idx == NUM_REQ - 1) ? '0 : PW'(idx + 1);
            end
        end
    end

    assign req_ready = grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            rf_we  <= 1'b0;
            rf_rd  <= '0;
            rf_d   <= '0;
        end else if (xfer) begin
            rr_ptr <= nxt_ptr;
            rf_rd  <= sel_rd;
            rf_d   <= sel_data;
            rf_we  <= (sel_rd != '0);
        end else begin
            rf_we  <= 1'b0;
        end
    end

    // A new issue to the same register outranks the commit of the previous producer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q[0] <= 1'b0;
            for (int unsigned r = 1; r < NUM_REGS; r++) begin
                if (iss_valid && iss_rd == AW'(r))
                    busy_q[r] <= 1'b1;
                else if (rf_we && rf_rd == AW'(r))
                    busy_q[r] <= 1'b0;
            end
        end
    end

    assign busy     = busy_q;
    assign hazard_a = busy_q[chk_ra];
    assign hazard_b = busy_q[chk_rb];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: arbitration order, write-stage latency,
// scoreboard set/clear priority and asynchronous reset.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [9:0]  req_rd;
    logic [63:0] req_data;
    logic [1:0]  req_ready;
    logic [4:0]  rf_rd;
    logic [31:0] rf_d;
    logic        rf_we;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  chk_ra;
    logic [4:0]  chk_rb;
    logic        hazard_a;
    logic        hazard_b;
    logic [31:0] busy;

    int passed = 0;
    int total  = 0;

    regfile_wb_arbiter #(
        .DATA_WIDTH(32),
        .NUM_REGS  (32),
        .NUM_REQ   (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_rd   (req_rd),
        .req_data (req_data),
        .req_ready(req_ready),
        .rf_rd    (rf_rd),
        .rf_d     (rf_d),
        .rf_we    (rf_we),
        .iss_valid(iss_valid),
        .iss_rd   (iss_rd),
        .chk_ra   (chk_ra),
        .chk_rb   (chk_rb),
        .hazard_a (hazard_a),
        .hazard_b (hazard_b),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_rd    = '0;
        req_data  = '0;
        iss_valid = 1'b0;
        iss_rd    = '0;
        chk_ra    = '0;
        chk_rb    = '0;
        #1;
        check("rst_rf_we", rf_we, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", req_ready, 0);
        check("rst_rf_rd", rf_rd, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1: single requester, 1-cycle write latency
        req_valid = 2'b01;
        req_rd    = {5'd0, 5'd5};
        req_data  = {32'h0, 32'hDEADBEEF};
        #1;
        check("t1_ready", req_ready, 2'b01);
        step();
        req_valid = '0;
        check("t1_we", rf_we, 1);
        check("t1_rd", rf_rd, 5);
        check("t1_d", rf_d, 32'hDEADBEEF);
        step();
        check("t1_we_drop", rf_we, 0);

        // 2: both valid from reset, grants alternate
        rst_n = 1'b0;
        #2;
        rst_n     = 1'b1;
        req_valid = 2'b11;
        req_rd    = {5'd2, 5'd1};
        req_data  = {32'h22, 32'h11};
        #1;
        check("t2_ready0", req_ready, 2'b01);
        step();
        check("t2_rd0", rf_rd, 1);
        check("t2_d0", rf_d, 32'h11);
        check("t2_ready1", req_ready, 2'b10);
        step();
        check("t2_rd1", rf_rd, 2);
        check("t2_d1", rf_d, 32'h22);
        check("t2_ready2", req_ready, 2'b01);
        step();
        check("t2_rd2", rf_rd, 1);
        check("t2_ready3", req_ready, 2'b10);
        step();
        req_valid = '0;
        check("t2_rd3", rf_rd, 2);
        check("t2_we3", rf_we, 1);

        // 3: rd=0 request from requester 1 alone
        req_valid = 2'b10;
        req_rd    = {5'd0, 5'd0};
        req_data  = {32'h1234, 32'h0};
        #1;
        check("t3_ready", req_ready, 2'b10);
        step();
        req_valid = '0;
        check("t3_we", rf_we, 0);
        check("t3_d", rf_d, 32'h1234);
        check("t3_busy", busy, 0);
        req_valid = 2'b11;
        #1;
        check("t3_ptr_back_to_0", req_ready, 2'b01);
        req_valid = '0;
        iss_valid = 1'b1;
        iss_rd    = 5'd0;
        step();
        iss_valid = 1'b0;
        check("t3_iss_x0", busy, 0);

        // 4: scoreboard set by issue, cleared by commit
        iss_valid = 1'b1;
        iss_rd    = 5'd7;
        chk_ra    = 5'd7;
        chk_rb    = 5'd0;
        #1;
        check("t4_haz_before", hazard_a, 0);
        step();
        iss_valid = 1'b0;
        check("t4_haz_set", hazard_a, 1);
        check("t4_busy_set", busy, 32'h80);
        check("t4_hazb0", hazard_b, 0);
        req_valid = 2'b01;
        req_rd    = {5'd0, 5'd7};
        req_data  = {32'h0, 32'h77};
        step();
        req_valid = '0;
        check("t4_we", rf_we, 1);
        check("t4_rd", rf_rd, 7);
        check("t4_haz_hold", hazard_a, 1);
        step();
        check("t4_busy_clr", busy, 0);
        check("t4_haz_clr", hazard_a, 0);
        check("t4_hazb0_end", hazard_b, 0);

        // 5: issue and commit of the same register on one edge
        iss_valid = 1'b1;
        iss_rd    = 5'd3;
        step();
        iss_valid = 1'b0;
        check("t5_busy_set", busy, 32'h08);
        req_valid = 2'b01;
        req_rd    = {5'd0, 5'd3};
        req_data  = {32'h0, 32'h33};
        step();
        req_valid = '0;
        check("t5_we", rf_we, 1);
        check("t5_rd", rf_rd, 3);
        iss_valid = 1'b1;
        iss_rd    = 5'd3;
        step();
        iss_valid = 1'b0;
        check("t5_set_wins", busy, 32'h08);

        // 6: asynchronous reset with a write in flight
        iss_valid = 1'b1;
        iss_rd    = 5'd7;
        req_valid = 2'b01;
        req_rd    = {5'd0, 5'd1};
        req_data  = {32'h0, 32'hAB};
        step();
        iss_valid = 1'b0;
        req_valid = '0;
        check("t6_busy_pre", busy, 32'h88);
        check("t6_we_pre", rf_we, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_we_async", rf_we, 0);
        check("t6_busy_async", busy, 0);
        check("t6_d_async", rf_d, 0);
        #2;
        rst_n     = 1'b1;
        req_valid = 2'b11;
        req_rd    = {5'd6, 5'd4};
        req_data  = {32'h66, 32'h44};
        #1;
        check("t6_first_grant", req_ready, 2'b01);
        step();
        req_valid = '0;
        check("t6_rd", rf_rd, 4);
        check("t6_we", rf_we, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (rd/d/we) among NUM_REQ writeback requesters, such as the ALU and load units.
- Arbitration is round-robin with valid/ready handshakes and a registered write stage.
- Contains a pending-write scoreboard: busy bit per register, set on instruction issue and cleared when the write commits.
- Sits between the execute/memory writeback paths and the register file; the issue stage uses its hazard outputs to stall.

Parameters:
- DATA_WIDTH, 32, bits per register / write data width
- NUM_REGS, 32, number of architectural registers; AW = $clog2(NUM_REGS)
- NUM_REQ, 2, number of writeback requesters (>=2); requester 0 is the lowest index

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- req_valid  input  NUM_REQ  requester i has a write pending
- req_rd  input  NUM_REQ*AW  destination register of requester i, slice [i*AW +: AW]
- req_data  input  NUM_REQ*DATA_WIDTH  write data of requester i, slice [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  output  NUM_REQ  one-hot grant; transfer when req_valid[i] && req_ready[i]
- rf_rd  output  AW  register file write address
- rf_d  output  DATA_WIDTH  register file write data
- rf_we  output  1  register file write enable
- iss_valid  input  1  issue stage dispatches an instruction that writes iss_rd
- iss_rd  input  AW  destination of issued instruction
- chk_ra  input  AW  source A to check
- chk_rb  input  AW  source B to check
- hazard_a  output  1  busy[chk_ra]
- hazard_b  output  1  busy[chk_rb]
- busy  output  NUM_REGS  scoreboard vector

Behaviour:
- Reset (rst_n=0, takes effect asynchronously):
  - rr_ptr=0, rf_we=0, rf_rd=0, rf_d=0, busy=all 0.
  - An in-flight registered write is discarded; rf_we falls immediately.
- Arbitration (combinational):
  - Grant g = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - req_ready = one-hot(g) when any valid, else 0.
  - req_ready never asserts for an invalid requester.
  - No backpressure from the register file, so a grant is issued every cycle some request is valid.
- rr_ptr update:
  - On a transfer, rr_ptr <= (g+1) mod NUM_REQ.
  - Unchanged when there is no transfer.
  - Guarantees no starvation: a continuously-valid requester waits at most NUM_REQ-1 cycles.
- Write stage, registered, 1-cycle latency:
  - On the transfer edge: rf_rd <= req_rd[g], rf_d <= req_data[g], rf_we <= (req_rd[g] != 0).
  - With no transfer: rf_we <= 0, and rf_rd/rf_d hold their values.
  - The register file captures the write on the next edge, so data is readable 2 edges after the handshake.
- rd=0 request: the handshake completes normally, rf_we stays 0, and the scoreboard is unaffected.
- Requester protocol: rd/data must be held stable while valid && !ready. Valid must not drop before the transfer.
- Scoreboard, per register r>0, at each rising edge:
  - set_r = iss_valid && iss_rd==r.
  - clr_r = rf_we && rf_rd==r (the write commits on this edge).
  - busy[r] <= set_r ? 1 : (clr_r ? 0 : busy[r]).
  - Simultaneous set and clear of the same r: set wins (the new producer is pending).
  - busy[0] is constant 0; iss_rd=0 is ignored.
- Issue while already busy: the bit stays 1 and clears on the first commit. Preventing WAW is the issue stage's job; it checks busy[iss_rd] before issuing.
- Hazards: hazard_a = busy[chk_ra], hazard_b = busy[chk_rb], purely combinational. Neither asserts for x0.
- Only registered state: rr_ptr, rf_rd, rf_d, rf_we, busy.

Test Plan:
1. Reset, then req_valid=01, req_rd[0]=5, data=0xDEADBEEF -> req_ready=01 same cycle; next cycle rf_we=1, rf_rd=5, rf_d=0xDEADBEEF; the cycle after that rf_we=0.
2. Both valid continuously from reset (req0 rd=1, req1 rd=2) -> grants alternate 01, 10, 01, ... and rf_rd sequence is 1, 2, 1, 2.
3. req1 rd=0, data=0x1234, alone -> req_ready=10; rf_we stays 0 the next cycle; busy unchanged; rr_ptr advances to 0.
4. iss_valid with iss_rd=7, then chk_ra=7 -> hazard_a=1 from the next cycle. Then a request with rd=7 -> busy[7] clears on the edge after rf_we=1 and hazard_a=0. chk_rb=0 -> hazard_b=0 always.
5. iss_valid iss_rd=3 on the same edge a commit with rf_rd=3, rf_we=1 occurs -> busy[3]=1 afterwards.
6. Assert rst_n=0 mid-cycle while rf_we=1 and busy=0x0000_0088 -> rf_we=0 and busy=0 immediately without a clock edge; after release, the first grant goes to requester 0.
